// File: rtl/transform_pkg.sv
// Shared types and constants for the transform sequencer: state encoding,
// engine mode encodings and default frame/latency settings.
package transform_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    EXEC = 3'd2,
    HOLD = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [1:0] MODE_HWT = 2'b11;
  localparam logic [1:0] MODE_DCT = 2'b00;
  localparam logic [1:0] MODE_DFT = 2'b10;
  localparam logic [1:0] MODE_BAD = 2'b01;

  localparam int DEF_N       = 8;
  localparam int DEF_HWT_LAT = 6;
  localparam int DEF_DCT_LAT = 8;
  localparam int DEF_DFT_LAT = 5;

endpackage

// File: rtl/phase_counter.sv
// CW-bit phase counter with synchronous clear, enable and a terminal-value
// compare; shared by the LOAD, EXEC and HOLD phases of the sequencer.
module phase_counter #(
  parameter int CW = 4
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] term,
  output logic [CW-1:0] count,
  output logic          at_term
);

  always_ff @(posedge clock) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign at_term = (count == term);

endmodule

// File: rtl/transform_sequencer.sv
// Frame sequencer: load N samples, run the selected transform engine, pad to
// max(LAT,N) cycles, then hold the result. Optional macro TS_CONT_EN adds `cont`.
//
// Handshakes: a sample transfers on an edge where in_valid && in_ready; a result
// is consumed on an edge where out_data_valid && out_ready, and held otherwise.
module transform_sequencer
  import transform_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int CW      = $clog2(N + 1),
  parameter int HWT_LAT = DEF_HWT_LAT,
  parameter int DCT_LAT = DEF_DCT_LAT,
  parameter int DFT_LAT = DEF_DFT_LAT
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          strt,
  input  logic [1:0]    sel,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          out_ready,
`ifdef TS_CONT_EN
  input  logic          cont,
`endif
  output logic          dl_en,
  output logic          dt_load,
  output logic          hwt_en,
  output logic          dct_en,
  output logic          dft_en,
  output logic          in_data_valid,
  output logic          out_data_valid,
  output logic          bank,
  output logic          busy,
  output logic          err,
  output logic [CW-1:0] count,
  output state_t        dbg_state
);

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    mode;
  int            lat;
  logic [CW-1:0] term;
  logic          cnt_clr;
  logic          cnt_en;
  logic          at_term;
  logic          start_ok;
  logic          frame_loaded;

  assign dbg_state    = state;
  assign start_ok     = strt && (sel != MODE_BAD);
  assign frame_loaded = (state == LOAD) && (state_nxt == EXEC);

  always_comb begin
    case (mode)
      MODE_HWT: lat = HWT_LAT;
      MODE_DFT: lat = DFT_LAT;
      default:  lat = DCT_LAT;
    endcase
  end

  // Next state plus counter control; the counter terminal tracks the phase.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    term      = '0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (start_ok) state_nxt = LOAD;
      end
      LOAD: begin
        term = CW'(N - 1);
        if (in_valid) begin
          if (at_term) begin
            cnt_clr   = 1'b1;
            state_nxt = EXEC;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      EXEC: begin
        term = CW'(lat - 1);
        if (at_term) begin
          cnt_clr   = 1'b1;
          state_nxt = (lat < N) ? HOLD : DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      HOLD: begin
        term = CW'(N - lat - 1);
        if (at_term) begin
          cnt_clr   = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        cnt_clr = 1'b1;
        if (out_ready) begin
`ifdef TS_CONT_EN
          state_nxt = cont ? LOAD : IDLE;
`else
          state_nxt = IDLE;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  phase_counter #(.CW(CW)) u_phase_counter (
    .clock   (clock),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .term    (term),
    .count   (count),
    .at_term (at_term)
  );

  // Outputs are decoded from state_nxt so they line up with the state register.
  always_ff @(posedge clock) begin
    if (rst) begin
      state          <= IDLE;
      mode           <= MODE_DCT;
      in_ready       <= 1'b0;
      dl_en          <= 1'b0;
      dt_load        <= 1'b0;
      hwt_en         <= 1'b0;
      dct_en         <= 1'b0;
      dft_en         <= 1'b0;
      in_data_valid  <= 1'b0;
      out_data_valid <= 1'b0;
      bank           <= 1'b0;
      busy           <= 1'b0;
      err            <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start_ok) mode <= sel;
      in_ready       <= (state_nxt == LOAD);
      dl_en          <= (state_nxt == LOAD);
      dt_load        <= (state_nxt == LOAD);
      hwt_en         <= (state_nxt == EXEC) && (mode == MODE_HWT);
      dct_en         <= (state_nxt == EXEC) && (mode == MODE_DCT);
      dft_en         <= (state_nxt == EXEC) && (mode == MODE_DFT);
      in_data_valid  <= frame_loaded;
      out_data_valid <= (state_nxt == DONE);
      bank           <= bank ^ frame_loaded;
      busy           <= (state_nxt != IDLE);
      err            <= (state == IDLE) && strt && (sel == MODE_BAD);
    end
  end

endmodule

// File: tb/tb_transform_sequencer.sv
// Directed bench for transform_sequencer with default parameters; the
// TS_CONT_EN section is active when the macro is defined for the build.
module tb_transform_sequencer;
  import transform_pkg::*;

  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);

  logic          clock;
  logic          rst;
  logic          strt;
  logic [1:0]    sel;
  logic          in_valid;
  logic          in_ready;
  logic          out_ready;
  logic          dl_en;
  logic          dt_load;
  logic          hwt_en;
  logic          dct_en;
  logic          dft_en;
  logic          in_data_valid;
  logic          out_data_valid;
  logic          bank;
  logic          busy;
  logic          err;
  logic [CW-1:0] count;
  state_t        dbg_state;
`ifdef TS_CONT_EN
  logic          cont;
`endif

  int   n_chk  = 0;
  int   n_fail = 0;
  logic exp_bank;

  transform_sequencer #(.N(N)) dut (
    .clock          (clock),
    .rst            (rst),
    .strt           (strt),
    .sel            (sel),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_ready      (out_ready),
`ifdef TS_CONT_EN
    .cont           (cont),
`endif
    .dl_en          (dl_en),
    .dt_load        (dt_load),
    .hwt_en         (hwt_en),
    .dct_en         (dct_en),
    .dft_en         (dft_en),
    .in_data_valid  (in_data_valid),
    .out_data_valid (out_data_valid),
    .bank           (bank),
    .busy           (busy),
    .err            (err),
    .count          (count),
    .dbg_state      (dbg_state)
  );

  // Clock and reset-free timing helpers
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " in_ready"}, in_ready, 0);
    chk({tag, " dl_en"}, dl_en, 0);
    chk({tag, " dt_load"}, dt_load, 0);
    chk({tag, " engines"}, {hwt_en, dct_en, dft_en}, 0);
    chk({tag, " in_data_valid"}, in_data_valid, 0);
    chk({tag, " out_data_valid"}, out_data_valid, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " err"}, err, 0);
    chk({tag, " count"}, count, 0);
    chk({tag, " bank"}, bank, exp_bank);
    chk({tag, " state"}, dbg_state, IDLE);
  endtask

  // One frame from IDLE; cycle c is the interval after the c-th edge from strt.
  task automatic run_frame(input logic [1:0] s, input int lat, input bit gaps,
                           input int rdly, input string tag);
    int load_len, per, xs, ds, de, cnt;
    logic [2:0] en_exp;
    string t;
    load_len = gaps ? 2 * N : N;
    per      = (lat > N) ? lat : N;
    xs       = load_len + 1;
    ds       = load_len + per + 1;
    de       = ds + rdly;
    strt = 1'b1; sel = s; in_valid = 1'b1; out_ready = 1'b1;
    next_cycle();
    strt = 1'b0;
    for (int c = 1; c <= de + 1; c++) begin
      in_valid  = gaps ? (c % 2 == 0) : 1'b1;
      out_ready = !(c >= ds && c < de);
      if (c == xs + 1) sel = ~s;
      if (c == xs) exp_bank = ~exp_bank;
      if (c <= load_len)    cnt = gaps ? (c - 1) / 2 : c - 1;
      else if (c < xs + lat) cnt = c - xs;
      else if (c < ds)      cnt = c - xs - lat;
      else                  cnt = 0;
      en_exp = (c >= xs && c < xs + lat) ?
               {s == MODE_HWT, s == MODE_DCT, s == MODE_DFT} : 3'b000;
      t = $sformatf("%s c%0d", tag, c);
      chk({t, " in_ready"}, in_ready, (c <= load_len));
      chk({t, " dl_en"}, dl_en, (c <= load_len));
      chk({t, " engines"}, {hwt_en, dct_en, dft_en}, en_exp);
      chk({t, " in_data_valid"}, in_data_valid, (c == xs));
      chk({t, " out_data_valid"}, out_data_valid, (c >= ds && c <= de));
      chk({t, " busy"}, busy, (c <= de));
      chk({t, " bank"}, bank, exp_bank);
      chk({t, " count"}, count, cnt);
      next_cycle();
    end
  endtask

  initial begin
    rst = 1'b1; strt = 1'b0; sel = MODE_DCT; in_valid = 1'b0; out_ready = 1'b0;
    exp_bank = 1'b0;
`ifdef TS_CONT_EN
    cont = 1'b0;
`endif
    repeat (2) next_cycle();
    chk_quiet("reset");
    rst = 1'b0;
    next_cycle();

    // HWT: 6 engine cycles + 2 pad cycles, result at cycle 17
    run_frame(MODE_HWT, 6, 1'b0, 0, "hwt");
    // DCT with in_valid on alternate cycles: 16-cycle LOAD, no HOLD
    run_frame(MODE_DCT, 8, 1'b1, 0, "dct_gaps");

    // Reset in the middle of an HWT EXEC phase
    strt = 1'b1; sel = MODE_HWT; in_valid = 1'b1; out_ready = 1'b1;
    next_cycle();
    strt = 1'b0;
    repeat (10) next_cycle();
    chk("rst_mid hwt_en c11", hwt_en, 1);
    chk("rst_mid count c11", count, 2);
    chk("rst_mid bank c11", bank, 1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    exp_bank = 1'b0;
    chk_quiet("rst_mid after");
    run_frame(MODE_HWT, 6, 1'b0, 0, "hwt_after_rst");

    // DFT with the consumer stalling for 10 DONE cycles
    run_frame(MODE_DFT, 5, 1'b0, 10, "dft_stall");

    // Illegal mode at start
    strt = 1'b1; sel = MODE_BAD;
    next_cycle();
    strt = 1'b0; sel = MODE_DCT;
    chk("bad_sel err", err, 1);
    chk("bad_sel busy", busy, 0);
    chk("bad_sel state", dbg_state, IDLE);
    chk("bad_sel engines", {hwt_en, dct_en, dft_en}, 0);
    chk("bad_sel in_ready", in_ready, 0);
    next_cycle();
    chk_quiet("bad_sel next");

`ifdef TS_CONT_EN
    // Back-to-back HWT frames through the continue path
    cont = 1'b1; strt = 1'b1; sel = MODE_HWT; in_valid = 1'b1; out_ready = 1'b1;
    next_cycle();
    strt = 1'b0;
    repeat (16) next_cycle();
    chk("cont c17 out_data_valid", out_data_valid, 1);
    chk("cont c17 bank", bank, ~exp_bank);
    next_cycle();
    cont = 1'b0;
    chk("cont c18 in_ready", in_ready, 1);
    chk("cont c18 busy", busy, 1);
    chk("cont c18 out_data_valid", out_data_valid, 0);
    chk("cont c18 count", count, 0);
    repeat (8) next_cycle();
    chk("cont c26 in_data_valid", in_data_valid, 1);
    chk("cont c26 bank", bank, exp_bank);
    chk("cont c26 hwt_en", hwt_en, 1);
    repeat (8) next_cycle();
    chk("cont c34 out_data_valid", out_data_valid, 1);
    next_cycle();
    chk_quiet("cont c35");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
